// File: rtl/gray_scan_pkg.sv
// Shared types and helpers for the Gray-coded scan sequencer.
package gray_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } step_op_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int unsigned GRAY_MAX_W = 32;

    // Callers zero-extend into the wide argument and truncate the result back to N bits.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_core.sv
// N-bit binary position register with load/inc/dec/hold; the Gray copy is
// derived from the next binary value so both registers always agree.
module gray_step_core
    import gray_scan_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  step_op_e     op_i,
    input  logic [N-1:0] load_val_i,
    output logic [N-1:0] bin_o,
    output logic [N-1:0] gray_o
);

    logic [N-1:0] bin_q;
    logic [N-1:0] bin_d;
    logic [N-1:0] gray_q;
    logic [N-1:0] gray_d;

    always_comb begin
        bin_d = bin_q;
        unique case (op_i)
            OP_LOAD: bin_d = load_val_i;
            OP_INC:  bin_d = bin_q + N'(1);
            OP_DEC:  bin_d = bin_q - N'(1);
            default: bin_d = bin_q;
        endcase
        gray_d = N'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;

endmodule

// File: rtl/gray_scan_ctrl.sv
// Scan sequencer: start/stop/pause FSM, latched scan parameters and
// one-cycle done/wrap/abort pulses around a Gray-coded step core.
module gray_scan_ctrl
    import gray_scan_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         dir,
    input  logic         wrap_en,
    input  logic [N-1:0] limit,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         busy,
    output logic         done,
    output logic         wrap,
    output logic         abort
);

    state_e       state_q, state_d;
    logic         dir_q, dir_d;
    logic         wrap_en_q, wrap_en_d;
    logic [N-1:0] limit_q, limit_d;
    logic         wrap_q, wrap_d;
    logic         abort_q, abort_d;
    step_op_e     op;
    logic [N-1:0] load_val;
    logic [N-1:0] start_val;
    logic [N-1:0] term_val;

    assign start_val = (dir_q == DIR_DOWN) ? limit_q : '0;
    assign term_val  = (dir_q == DIR_DOWN) ? '0 : limit_q;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        wrap_en_d = wrap_en_q;
        limit_d   = limit_q;
        wrap_d    = 1'b0;
        abort_d   = 1'b0;
        op        = OP_HOLD;
        load_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Load from the raw inputs: the latches only update at this same edge.
                    dir_d     = dir;
                    wrap_en_d = wrap_en;
                    limit_d   = limit;
                    op        = OP_LOAD;
                    load_val  = (dir == DIR_DOWN) ? limit : '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end else if (bin_out != term_val) begin
                    op = (dir_q == DIR_DOWN) ? OP_DEC : OP_INC;
                end else if (wrap_en_q) begin
                    op       = OP_LOAD;
                    load_val = start_val;
                    wrap_d   = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            HOLD: begin
                if (stop) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            wrap_en_q <= 1'b0;
            limit_q   <= '0;
            wrap_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            wrap_en_q <= wrap_en_d;
            limit_q   <= limit_d;
            wrap_q    <= wrap_d;
            abort_q   <= abort_d;
        end
    end

    gray_step_core #(.N(N)) u_core (
        .clk        (clk),
        .rst        (rst),
        .op_i       (op),
        .load_val_i (load_val),
        .bin_o      (bin_out),
        .gray_o     (gray_out)
    );

    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = (state_q == DONE);
    assign wrap  = wrap_q;
    assign abort = abort_q;

endmodule

// File: tb/tb_gray_scan_ctrl.sv
// Bench for gray_scan_ctrl: directed scenarios plus random control traffic,
// every cycle compared against a behavioural scan model.
module tb_gray_scan_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         pause = 1'b0;
    logic         dir = 1'b0;
    logic         wrap_en = 1'b0;
    logic [N-1:0] limit = '0;
    logic [N-1:0] bin_out;
    logic [N-1:0] gray_out;
    logic         busy;
    logic         done;
    logic         wrap;
    logic         abort;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_scan_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .dir      (dir),
        .wrap_en  (wrap_en),
        .limit    (limit),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .abort    (abort)
    );

    // Behavioural model: a scan is "active" between start and its end,
    // may be frozen by pause, and a finished one-shot shows done for a cycle.
    bit m_active, m_paused, m_fin, m_dir, m_wen, m_wrap, m_abort;
    int m_bin, m_lim;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int term_v, start_v;
        m_wrap  = 1'b0;
        m_abort = 1'b0;
        if (!rst) begin
            m_active = 0; m_paused = 0; m_fin = 0;
            m_dir = 0; m_wen = 0; m_lim = 0; m_bin = 0;
            return;
        end
        term_v  = m_dir ? 0 : m_lim;
        start_v = m_dir ? m_lim : 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (!m_active) begin
            if (start) begin
                m_dir = dir; m_wen = wrap_en; m_lim = int'(limit);
                m_bin = dir ? int'(limit) : 0;
                m_active = 1; m_paused = 0;
            end
        end else if (stop) begin
            m_active = 0; m_paused = 0; m_abort = 1;
        end else if (m_paused) begin
            m_paused = pause;
        end else if (pause) begin
            m_paused = 1;
        end else if (m_bin != term_v) begin
            m_bin = m_dir ? m_bin - 1 : m_bin + 1;
        end else if (m_wen) begin
            m_bin = start_v; m_wrap = 1;
        end else begin
            m_active = 0; m_fin = 1;
        end
    endtask

    task automatic compare_all();
        check("bin_out",  32'(bin_out),  32'(m_bin));
        check("gray_out", 32'(gray_out), 32'(m_bin ^ (m_bin >> 1)));
        check("busy",     32'(busy),     32'(m_active));
        check("done",     32'(done),     32'(m_fin));
        check("wrap",     32'(wrap),     32'(m_wrap));
        check("abort",    32'(abort),    32'(m_abort));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic go(input logic d, input logic w, input int l);
        dir = d; wrap_en = w; limit = N'(l); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [N-1:0] prev_gray;
        int           cnt2;

        // Reset held with start asserted: nothing may start.
        rst = 1'b0; start = 1'b1; limit = 4'd9;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bin", 32'(bin_out), 32'd0);
        start = 1'b0; rst = 1'b1;
        step();
        check("idle_after_rst", 32'(busy), 32'd0);

        // Up, one-shot, limit 5.
        go(1'b0, 1'b0, 5);
        for (int i = 0; i < 5; i++) step();
        check("t2_last_gray", 32'(gray_out), 32'h7);
        step();
        check("t2_done", 32'(done), 32'd1);
        check("t2_done_bin", 32'(bin_out), 32'd5);
        check("t2_done_busy", 32'(busy), 32'd0);
        step();
        check("t2_idle_done", 32'(done), 32'd0);

        // Down, continuous, full range: Gray adjacency across wraps.
        go(1'b1, 1'b1, 15);
        check("t3_g0", 32'(gray_out), 32'h8);
        prev_gray = gray_out;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i < 3) check($sformatf("t3_g%0d", i + 1), 32'(gray_out), (i == 0) ? 32'h9 : (i == 1) ? 32'hB : 32'hA);
            if (m_bin == 15) check("t3_wrap_pulse", 32'(wrap), 32'd1);
            check("t3_one_bit", 32'($countones(gray_out ^ prev_gray)), 32'd1);
            prev_gray = gray_out;
        end
        stop = 1'b1; step(); stop = 1'b0;
        check("t3_abort", 32'(abort), 32'd1);

        // Pause for 3 cycles at bin 2.
        go(1'b0, 1'b0, 9);
        for (int i = 0; i < 10 && m_bin != 2; i++) step();
        cnt2 = 1;
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); if (bin_out == 4'd2) cnt2++; end
        pause = 1'b0;
        step(); if (bin_out == 4'd2) cnt2++;
        step(); if (bin_out == 4'd2) cnt2++;
        check("t4_hold_cycles", 32'(cnt2), 32'd5);
        check("t4_resume_bin", 32'(bin_out), 32'd3);
        check("t4_busy", 32'(busy), 32'd1);

        // Stop beats pause; a coincident start is ignored.
        stop = 1'b1; step(); stop = 1'b0;
        check("t4_stop", 32'(abort), 32'd1);
        step();
        go(1'b0, 1'b0, 9);
        for (int i = 0; i < 10 && m_bin != 3; i++) step();
        stop = 1'b1; pause = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; pause = 1'b0; start = 1'b0;
        check("t5_abort", 32'(abort), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_bin", 32'(bin_out), 32'd3);
        step();
        check("t5_no_restart", 32'(busy), 32'd0);

        // Mid-scan reset, then limit 0 one-shot.
        go(1'b0, 1'b1, 12);
        for (int i = 0; i < 10 && m_bin != 7; i++) step();
        rst = 1'b0; step(); rst = 1'b1;
        check("t6_rst_bin", 32'(bin_out), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        go(1'b0, 1'b0, 0);
        check("t6_l0_busy", 32'(busy), 32'd1);
        step();
        check("t6_l0_done", 32'(done), 32'd1);
        step();

        // Random control traffic.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) != 0);
            start   = ($urandom_range(0, 5) == 0);
            stop    = ($urandom_range(0, 39) == 0);
            pause   = ($urandom_range(0, 7) == 0);
            dir     = 1'($urandom_range(0, 1));
            wrap_en = 1'($urandom_range(0, 1));
            limit   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 2)) : N'($urandom_range(0, 15));
            step();
            check("excl_pulses", 32'(done + wrap + abort <= 1), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
